// File: rtl/decode_fault_req_if.sv
// Bus bundle between fetch, decode fault register, next decode stage and exception manager.
// Optional fault counters are present when CORE_DECODE_FAULT_CNT_EN is defined.
interface decode_fault_req_if;
    logic        iFLUSH;
    logic        iPREV_VALID;
    logic [31:0] iPREV_PC;
    logic [31:0] iPREV_INST;
    logic        iPREV_IRQ40;
    logic        iPREV_IRQ41;
    logic        iPREV_IRQ42;
    logic        oPREV_LOCK;
    logic        oNEXT_VALID;
    logic [31:0] oNEXT_PC;
    logic [31:0] oNEXT_INST;
    logic        iNEXT_LOCK;
    logic        oEXCEPT_REQ;
    logic [6:0]  oEXCEPT_NUM;
    logic [31:0] oEXCEPT_PC;
    logic        iEXCEPT_ACK;
`ifdef CORE_DECODE_FAULT_CNT_EN
    logic [7:0]  oFAULT_CNT40;
    logic [7:0]  oFAULT_CNT41;
    logic [7:0]  oFAULT_CNT42;
`endif

    // Environment side: drives the i* signals, observes the o* signals.
    modport master (
        output iFLUSH, iPREV_VALID, iPREV_PC, iPREV_INST,
        output iPREV_IRQ40, iPREV_IRQ41, iPREV_IRQ42, iNEXT_LOCK, iEXCEPT_ACK,
        input  oPREV_LOCK, oNEXT_VALID, oNEXT_PC, oNEXT_INST,
        input  oEXCEPT_REQ, oEXCEPT_NUM, oEXCEPT_PC
`ifdef CORE_DECODE_FAULT_CNT_EN
        , input oFAULT_CNT40, oFAULT_CNT41, oFAULT_CNT42
`endif
    );

    modport slave (
        input  iFLUSH, iPREV_VALID, iPREV_PC, iPREV_INST,
        input  iPREV_IRQ40, iPREV_IRQ41, iPREV_IRQ42, iNEXT_LOCK, iEXCEPT_ACK,
        output oPREV_LOCK, oNEXT_VALID, oNEXT_PC, oNEXT_INST,
        output oEXCEPT_REQ, oEXCEPT_NUM, oEXCEPT_PC
`ifdef CORE_DECODE_FAULT_CNT_EN
        , output oFAULT_CNT40, oFAULT_CNT41, oFAULT_CNT42
`endif
    );
endinterface

// File: rtl/decode_fault_req.sv
// Decode-stage fault request register: forwards clean instructions, turns a faulting one into
// a held exception request and locks upstream until flush. Macro CORE_DECODE_FAULT_CNT_EN adds fault counters.
module decode_fault_req (
    input  logic              iCLOCK,
    input  logic              iRESET,
    decode_fault_req_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        REQ        = 2'd1,
        WAIT_FLUSH = 2'd2
    } state_t;

    state_t      state;
    state_t      state_n;
    logic        fault;
    logic        accept;
    logic        fault_accept;
    logic        clean_accept;
    logic [6:0]  cause;

    assign fault           = bus.iPREV_IRQ40 || bus.iPREV_IRQ41 || bus.iPREV_IRQ42;
    assign bus.oPREV_LOCK  = bus.iNEXT_LOCK || (state != IDLE);
    assign accept          = bus.iPREV_VALID && !bus.oPREV_LOCK;
    // A flush discards whatever is presented in the same cycle.
    assign fault_accept    = accept && fault && !bus.iFLUSH;
    assign clean_accept    = accept && !fault && !bus.iFLUSH;
    assign bus.oEXCEPT_REQ = (state == REQ);

    always_comb begin
        if (bus.iPREV_IRQ40)      cause = 7'd40;
        else if (bus.iPREV_IRQ41) cause = 7'd41;
        else                      cause = 7'd42;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge iCLOCK or posedge iRESET) begin
        if (iRESET) state <= IDLE;
        else        state <= state_n;
    end

    // NOTE: state_n gets its default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_n = state;
        if (bus.iFLUSH) begin
            state_n = IDLE;
        end else begin
            unique case (state)
                IDLE:       if (fault_accept)    state_n = REQ;
                REQ:        if (bus.iEXCEPT_ACK) state_n = WAIT_FLUSH;
                WAIT_FLUSH: state_n = WAIT_FLUSH;
                default:    state_n = IDLE;
            endcase
        end
    end

    // Forward path; the PC/instruction registers keep their contents across a flush.
    always_ff @(posedge iCLOCK or posedge iRESET) begin
        if (iRESET) begin
            bus.oNEXT_VALID <= 1'b0;
            bus.oNEXT_PC    <= 32'd0;
            bus.oNEXT_INST  <= 32'd0;
        end else if (bus.iFLUSH) begin
            bus.oNEXT_VALID <= 1'b0;
        end else if (clean_accept) begin
            bus.oNEXT_VALID <= 1'b1;
            bus.oNEXT_PC    <= bus.iPREV_PC;
            bus.oNEXT_INST  <= bus.iPREV_INST;
        end else if (!bus.iNEXT_LOCK) begin
            bus.oNEXT_VALID <= 1'b0;
        end
    end

    always_ff @(posedge iCLOCK or posedge iRESET) begin
        if (iRESET) begin
            bus.oEXCEPT_NUM <= 7'd0;
            bus.oEXCEPT_PC  <= 32'd0;
        end else if (fault_accept) begin
            bus.oEXCEPT_NUM <= cause;
            bus.oEXCEPT_PC  <= bus.iPREV_PC;
        end
    end

`ifdef CORE_DECODE_FAULT_CNT_EN
    // Saturating per-cause counters; only iRESET clears them.
    always_ff @(posedge iCLOCK or posedge iRESET) begin
        if (iRESET) begin
            bus.oFAULT_CNT40 <= 8'd0;
            bus.oFAULT_CNT41 <= 8'd0;
            bus.oFAULT_CNT42 <= 8'd0;
        end else if (fault_accept) begin
            if (cause == 7'd40 && bus.oFAULT_CNT40 != 8'hFF) bus.oFAULT_CNT40 <= bus.oFAULT_CNT40 + 8'd1;
            if (cause == 7'd41 && bus.oFAULT_CNT41 != 8'hFF) bus.oFAULT_CNT41 <= bus.oFAULT_CNT41 + 8'd1;
            if (cause == 7'd42 && bus.oFAULT_CNT42 != 8'hFF) bus.oFAULT_CNT42 <= bus.oFAULT_CNT42 + 8'd1;
        end
    end
`endif

endmodule
